// File: rtl/memaccess_dmem_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : memaccess_dmem_resp_if
// Description : Request/response bundle between a data-memory requester
//               (master) and the memaccess_dmem_resp responder (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface memaccess_dmem_resp_if;
  logic [1:0]  mem_state;   // 0 read, 1 indirect read, 2 write, 3 idle
  logic [15:0] DMem_addr;
  logic [15:0] DMem_din;
  logic        DMem_rd;     // 1 read request, 0 write request
  logic [15:0] DMem_dout;
  logic        dout_valid;
  logic        busy;
  logic        addr_err;
  logic        proto_err;

  modport master (
    output mem_state, DMem_addr, DMem_din, DMem_rd,
    input  DMem_dout, dout_valid, busy, addr_err, proto_err
  );

  modport slave (
    input  mem_state, DMem_addr, DMem_din, DMem_rd,
    output DMem_dout, dout_valid, busy, addr_err, proto_err
  );
endinterface
`default_nettype wire

// File: rtl/memaccess_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : memaccess_dmem_resp
// Description : 16-bit data memory with single-cycle writes and a fixed
//               RD_LAT-cycle read response, sticky address/protocol errors.
//               Optional macro MEMACCESS_DMEM_WR_FWD_EN: writes that hit the
//               address of an outstanding read update the pending response.
// Revision    : 1.0  initial release
// ============================================================================
module memaccess_dmem_resp #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  wire logic             clock,
  input  wire logic             reset,
  memaccess_dmem_resp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] MS_READ  = 2'd0;
  localparam logic [1:0] MS_IREAD = 2'd1;
  localparam logic [1:0] MS_WRITE = 2'd2;

  // WAIT lasts RD_LAT-1 cycles; the counter counts down to zero inside it
  localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("memaccess_dmem_resp: RD_LAT must be in 1..4");
  end

  logic [15:0]       mem_q [0:DEPTH-1];

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [15:0]       cap_q, cap_d;
  logic [15:0]       dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              addr_err_q, addr_err_d;
  logic              proto_err_q, proto_err_d;
`ifdef MEMACCESS_DMEM_WR_FWD_EN
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
`endif

  logic [ADDR_W-1:0] idx;
  logic              addr_hi;
  logic              rd_phase;
  logic              wr_req;
  logic              rd_req;
  logic              mismatch;
  logic              busy;
  logic              rd_acc;
  logic              rd_drop;

  assign idx      = bus.DMem_addr[ADDR_W-1:0];
  assign addr_hi  = (bus.DMem_addr >> ADDR_W) != 16'h0000;
  assign rd_phase = (bus.mem_state == MS_READ) || (bus.mem_state == MS_IREAD);
  assign wr_req   = (bus.mem_state == MS_WRITE) && !bus.DMem_rd;
  assign rd_req   = rd_phase && bus.DMem_rd;
  assign mismatch = ((bus.mem_state == MS_WRITE) && bus.DMem_rd) ||
                    (rd_phase && !bus.DMem_rd);
  assign busy     = (state_q != ST_IDLE);
  assign rd_acc   = rd_req && !busy;
  assign rd_drop  = rd_req && busy;

  // Next-state logic: read sequencing, response loading and sticky errors
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    addr_err_d  = addr_err_q | ((rd_acc | wr_req) & addr_hi);
    proto_err_d = proto_err_q | mismatch | rd_drop;
`ifdef MEMACCESS_DMEM_WR_FWD_EN
    cap_addr_d  = cap_addr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rd_acc) begin
          // Array write is non-blocking, so this is the pre-write contents
          cap_d   = mem_q[idx];
`ifdef MEMACCESS_DMEM_WR_FWD_EN
          cap_addr_d = idx;
`endif
          cnt_d   = WAIT_INIT;
          state_d = (RD_LAT > 1) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        dout_d  = cap_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef MEMACCESS_DMEM_WR_FWD_EN
    // A write hitting the pending address overrides the captured word,
    // including on the final edge where the response is loaded
    if (wr_req && busy && (idx == cap_addr_q)) begin
      cap_d = bus.DMem_din;
      if (state_q == ST_RESP) begin
        dout_d = bus.DMem_din;
      end
    end
`endif
  end

  // Control and response registers, cleared asynchronously on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      cap_q       <= 16'h0000;
      dout_q      <= 16'h0000;
      valid_q     <= 1'b0;
      addr_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
`ifdef MEMACCESS_DMEM_WR_FWD_EN
      cap_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      addr_err_q  <= addr_err_d;
      proto_err_q <= proto_err_d;
`ifdef MEMACCESS_DMEM_WR_FWD_EN
      cap_addr_q  <= cap_addr_d;
`endif
    end
  end

  // Storage array: single-cycle writes in any state, contents never reset
  always_ff @(posedge clock) begin
    if (wr_req) begin
      mem_q[idx] <= bus.DMem_din;
    end
  end

  assign bus.DMem_dout  = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy;
  assign bus.addr_err   = addr_err_q;
  assign bus.proto_err  = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_memaccess_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_memaccess_dmem_resp
// Description : Self-checking bench; one instance with RD_LAT=1 and one with
//               RD_LAT=3, expected responses queued at stimulus time.
// Revision    : 1.0  initial release
// ============================================================================
module tb_memaccess_dmem_resp;

  localparam int RL3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  memaccess_dmem_resp_if b1 ();
  memaccess_dmem_resp_if b3 ();

  memaccess_dmem_resp #(.ADDR_W(8), .RD_LAT(1)) dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (b1)
  );

  memaccess_dmem_resp #(.ADDR_W(8), .RD_LAT(RL3)) dut3 (
    .clock (clk),
    .reset (rst),
    .bus   (b3)
  );

  typedef struct {
    logic [15:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp1[$];
  exp_t exp3[$];

  int vectors     = 0;
  int miscompares = 0;

  // observed responses, written only by the monitor
  logic [15:0] od1 [0:63];
  logic [31:0] oc1 [0:63];
  logic [15:0] od3 [0:63];
  logic [31:0] oc3 [0:63];
  int ocnt1 = 0;
  int ocnt3 = 0;
  int bc1   = 0;
  int bc3   = 0;

  // monitor: record each response with its cycle stamp, count busy cycles
  always @(negedge clk) begin
    if (b1.dout_valid) begin
      od1[ocnt1[5:0]] <= b1.DMem_dout;
      oc1[ocnt1[5:0]] <= cyc;
      ocnt1 <= ocnt1 + 1;
    end
    if (b1.busy) bc1 <= bc1 + 1;
    if (b3.dout_valid) begin
      od3[ocnt3[5:0]] <= b3.DMem_dout;
      oc3[ocnt3[5:0]] <= cyc;
      ocnt3 <= ocnt3 + 1;
    end
    if (b3.busy) bc3 <= bc3 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic [1:0] st, input logic [15:0] a,
                      input logic [15:0] d, input logic rd);
    b1.mem_state = st;
    b1.DMem_addr = a;
    b1.DMem_din  = d;
    b1.DMem_rd   = rd;
  endtask

  task automatic drv3(input logic [1:0] st, input logic [15:0] a,
                      input logic [15:0] d, input logic rd);
    b3.mem_state = st;
    b3.DMem_addr = a;
    b3.DMem_din  = d;
    b3.DMem_rd   = rd;
  endtask

  task automatic idle3();
    drv3(2'd3, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic wr3(input logic [15:0] a, input logic [15:0] d);
    drv3(2'd2, a, d, 1'b0);
    tick();
    idle3();
  endtask

  // issue a read on the RD_LAT=3 instance and queue the expected response
  task automatic rd3(input logic [15:0] a, input logic [15:0] want);
    drv3(2'd0, a, 16'h0000, 1'b1);
    tick();
    exp3.push_back('{data: want, cyc: cyc + 32'(RL3)});
    idle3();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    vectors++;
    if ({b1.DMem_dout, b1.dout_valid, b1.busy, b1.addr_err, b1.proto_err} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_dut1: got dout=%h v=%b b=%b ae=%b pe=%b, want all zero",
               b1.DMem_dout, b1.dout_valid, b1.busy, b1.addr_err, b1.proto_err);
    end
    vectors++;
    if ({b3.DMem_dout, b3.dout_valid, b3.busy, b3.addr_err, b3.proto_err} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_dut3: got dout=%h v=%b b=%b ae=%b pe=%b, want all zero",
               b3.DMem_dout, b3.dout_valid, b3.busy, b3.addr_err, b3.proto_err);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rdlat1();
    exp_t e;
    int n0, bb0;
    drv1(2'd2, 16'h0012, 16'hBEEF, 1'b0);
    tick();
    n0 = ocnt1;
    drv1(2'd0, 16'h0012, 16'h0000, 1'b1);
    tick();
    exp1.push_back('{data: 16'hBEEF, cyc: cyc + 32'd1});
    bb0 = bc1;
    drv1(2'd3, 16'h0000, 16'h0000, 1'b0);
    repeat (3) tick();
    e = exp1.pop_front();
    vectors++;
    if (ocnt1 - n0 != 1 || od1[n0[5:0]] !== e.data || oc1[n0[5:0]] !== e.cyc) begin
      miscompares++;
      $display("FAIL lat1_resp: got n=%0d data=%h cyc=%0d, want n=1 data=%h cyc=%0d",
               ocnt1 - n0, od1[n0[5:0]], oc1[n0[5:0]], e.data, e.cyc);
    end
    vectors++;
    if (bc1 - bb0 != 1) begin
      miscompares++;
      $display("FAIL lat1_busy: got %0d busy cycles, want 1", bc1 - bb0);
    end
    vectors++;
    if ({b1.addr_err, b1.proto_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL lat1_err: got ae=%b pe=%b, want 0 0", b1.addr_err, b1.proto_err);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n0, bb0;
    do_reset();
    wr3(16'h0012, 16'h1234);
    wr3(16'h0013, 16'h0099);
    n0 = ocnt3;
    rd3(16'h0012, 16'h1234);
    bb0 = bc3;
    drv3(2'd0, 16'h0013, 16'h0000, 1'b1);
    tick();
    idle3();
    repeat (5) tick();
    e = exp3.pop_front();
    vectors++;
    if (ocnt3 - n0 != 1 || od3[n0[5:0]] !== e.data || oc3[n0[5:0]] !== e.cyc) begin
      miscompares++;
      $display("FAIL b2b_resp: got n=%0d data=%h cyc=%0d, want n=1 data=%h cyc=%0d",
               ocnt3 - n0, od3[n0[5:0]], oc3[n0[5:0]], e.data, e.cyc);
    end
    vectors++;
    if (b3.proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_proto: got %b, want 1", b3.proto_err);
    end
    vectors++;
    if (b3.DMem_dout !== 16'h1234) begin
      miscompares++;
      $display("FAIL b2b_hold: got %h, want 1234", b3.DMem_dout);
    end
    vectors++;
    if (bc3 - bb0 != RL3) begin
      miscompares++;
      $display("FAIL b2b_busy: got %0d busy cycles, want %0d", bc3 - bb0, RL3);
    end
  endtask

  task automatic test_wr_fwd();
    exp_t e;
    int n0;
    logic [15:0] want;
`ifdef MEMACCESS_DMEM_WR_FWD_EN
    want = 16'h2222;
`else
    want = 16'h1111;
`endif
    do_reset();
    wr3(16'h0040, 16'h1111);
    n0 = ocnt3;
    rd3(16'h0040, want);
    drv3(2'd2, 16'h0040, 16'h2222, 1'b0);
    tick();
    idle3();
    repeat (4) tick();
    e = exp3.pop_front();
    vectors++;
    if (ocnt3 - n0 != 1 || od3[n0[5:0]] !== e.data || oc3[n0[5:0]] !== e.cyc) begin
      miscompares++;
      $display("FAIL fwd_resp: got n=%0d data=%h cyc=%0d, want n=1 data=%h cyc=%0d",
               ocnt3 - n0, od3[n0[5:0]], oc3[n0[5:0]], e.data, e.cyc);
    end
    vectors++;
    if ({b3.addr_err, b3.proto_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL fwd_err: got ae=%b pe=%b, want 0 0", b3.addr_err, b3.proto_err);
    end
    n0 = ocnt3;
    rd3(16'h0040, 16'h2222);
    repeat (4) tick();
    e = exp3.pop_front();
    vectors++;
    if (ocnt3 - n0 != 1 || od3[n0[5:0]] !== e.data || oc3[n0[5:0]] !== e.cyc) begin
      miscompares++;
      $display("FAIL fwd_array: got n=%0d data=%h cyc=%0d, want n=1 data=%h cyc=%0d",
               ocnt3 - n0, od3[n0[5:0]], oc3[n0[5:0]], e.data, e.cyc);
    end
  endtask

  task automatic test_addr_err();
    exp_t e;
    int n0;
    do_reset();
    wr3(16'h0105, 16'h5A5A);
    vectors++;
    if (b3.addr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL aerr_set: got %b, want 1", b3.addr_err);
    end
    n0 = ocnt3;
    rd3(16'h0005, 16'h5A5A);
    repeat (4) tick();
    e = exp3.pop_front();
    vectors++;
    if (ocnt3 - n0 != 1 || od3[n0[5:0]] !== e.data || oc3[n0[5:0]] !== e.cyc) begin
      miscompares++;
      $display("FAIL aerr_alias: got n=%0d data=%h cyc=%0d, want n=1 data=%h cyc=%0d",
               ocnt3 - n0, od3[n0[5:0]], oc3[n0[5:0]], e.data, e.cyc);
    end
    vectors++;
    if ({b3.addr_err, b3.proto_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL aerr_sticky: got ae=%b pe=%b, want 1 0", b3.addr_err, b3.proto_err);
    end
  endtask

  task automatic test_proto();
    exp_t e;
    int n0;
    do_reset();
    drv3(2'd0, 16'h0020, 16'h0000, 1'b0);
    tick();
    idle3();
    vectors++;
    if ({b3.proto_err, b3.busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL proto_rd0: got pe=%b busy=%b, want 1 0", b3.proto_err, b3.busy);
    end
    do_reset();
    wr3(16'h0020, 16'h7777);
    wr3(16'h0021, 16'h4444);
    drv3(2'd2, 16'h0020, 16'hDEAD, 1'b1);
    tick();
    idle3();
    vectors++;
    if (b3.proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL proto_wr1: got %b, want 1", b3.proto_err);
    end
    n0 = ocnt3;
    rd3(16'h0020, 16'h7777);
    repeat (4) tick();
    e = exp3.pop_front();
    vectors++;
    if (ocnt3 - n0 != 1 || od3[n0[5:0]] !== e.data || oc3[n0[5:0]] !== e.cyc) begin
      miscompares++;
      $display("FAIL proto_nowrite: got n=%0d data=%h cyc=%0d, want n=1 data=%h cyc=%0d",
               ocnt3 - n0, od3[n0[5:0]], oc3[n0[5:0]], e.data, e.cyc);
    end
    drv3(2'd3, 16'h0021, 16'hFFFF, 1'b1);
    tick();
    drv3(2'd3, 16'h0121, 16'hFFFF, 1'b0);
    tick();
    idle3();
    tick();
    vectors++;
    if ({b3.DMem_dout, b3.dout_valid, b3.busy, b3.addr_err, b3.proto_err} !== {16'h7777, 4'b0001}
        || ocnt3 - n0 != 1) begin
      miscompares++;
      $display("FAIL idle_nochg: got dout=%h v=%b b=%b ae=%b pe=%b n=%0d, want 7777 0 0 0 1 n=1",
               b3.DMem_dout, b3.dout_valid, b3.busy, b3.addr_err, b3.proto_err, ocnt3 - n0);
    end
    n0 = ocnt3;
    rd3(16'h0021, 16'h4444);
    repeat (4) tick();
    e = exp3.pop_front();
    vectors++;
    if (ocnt3 - n0 != 1 || od3[n0[5:0]] !== e.data || oc3[n0[5:0]] !== e.cyc) begin
      miscompares++;
      $display("FAIL idle_nowrite: got n=%0d data=%h cyc=%0d, want n=1 data=%h cyc=%0d",
               ocnt3 - n0, od3[n0[5:0]], oc3[n0[5:0]], e.data, e.cyc);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int n0;
    do_reset();
    wr3(16'h0030, 16'hABCD);
    n0 = ocnt3;
    rd3(16'h0030, 16'hABCD);
    repeat (4) tick();
    e = exp3.pop_front();
    vectors++;
    if (ocnt3 - n0 != 1 || od3[n0[5:0]] !== e.data || oc3[n0[5:0]] !== e.cyc) begin
      miscompares++;
      $display("FAIL rmid_pre: got n=%0d data=%h cyc=%0d, want n=1 data=%h cyc=%0d",
               ocnt3 - n0, od3[n0[5:0]], oc3[n0[5:0]], e.data, e.cyc);
    end
    wr3(16'h0131, 16'h0001);
    drv3(2'd1, 16'h0030, 16'h0000, 1'b0);
    tick();
    idle3();
    vectors++;
    if ({b3.DMem_dout, b3.addr_err, b3.proto_err} !== {16'hABCD, 2'b11}) begin
      miscompares++;
      $display("FAIL rmid_setup: got dout=%h ae=%b pe=%b, want abcd 1 1",
               b3.DMem_dout, b3.addr_err, b3.proto_err);
    end
    n0 = ocnt3;
    drv3(2'd1, 16'h0030, 16'h0000, 1'b1);
    tick();
    idle3();
    vectors++;
    if (b3.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_busy: got %b, want 1", b3.busy);
    end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({b3.DMem_dout, b3.dout_valid, b3.busy, b3.addr_err, b3.proto_err} !== 20'h0) begin
      miscompares++;
      $display("FAIL rmid_clear: got dout=%h v=%b b=%b ae=%b pe=%b, want all zero",
               b3.DMem_dout, b3.dout_valid, b3.busy, b3.addr_err, b3.proto_err);
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    vectors++;
    if (ocnt3 != n0 || b3.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_abort: got %0d responses busy=%b, want 0 responses busy=0",
               ocnt3 - n0, b3.busy);
    end
  endtask

  initial begin
    drv1(2'd3, 16'h0000, 16'h0000, 1'b0);
    idle3();
    test_reset();
    test_rdlat1();
    test_back_to_back();
    test_wr_fwd();
    test_addr_err();
    test_proto();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
